// File: rtl/mod.sv
// Start/stop tick generator: emits a one-cycle tick every DIV cycles while running,
// with a toggling square wave and a saturating tick counter.
module mod #(
  parameter int unsigned DIV = 42
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  output logic        tick,
  output logic        wave,
  output logic        busy,
  output logic [7:0]  cnt_q,
  output logic [15:0] tick_cnt
);

  // state | meaning
  // IDLE  | halted; phase counter at 0, wave and tick_cnt held
  // RUN   | counting phase, ticking every DIV cycles
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [7:0] LAST = 8'(DIV - 1);

  state_t      state, state_n;
  logic [7:0]  cnt_n;
  logic        tick_n;
  logic        wave_n;
  logic [15:0] tick_cnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt_q    <= 8'd0;
      tick     <= 1'b0;
      wave     <= 1'b0;
      tick_cnt <= 16'd0;
    end else begin
      state    <= state_n;
      cnt_q    <= cnt_n;
      tick     <= tick_n;
      wave     <= wave_n;
      tick_cnt <= tick_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt_q;
    tick_n     = 1'b0;
    wave_n     = wave;
    tick_cnt_n = tick_cnt;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n = RUN;
          cnt_n   = 8'd0;
        end
      end
      RUN: begin
        // stop outranks the terminal count, so a stop on the last phase swallows the tick
        if (stop) begin
          state_n = IDLE;
          cnt_n   = 8'd0;
        end else if (cnt_q == LAST) begin
          cnt_n  = 8'd0;
          tick_n = 1'b1;
          wave_n = ~wave;
          if (tick_cnt != 16'hFFFF) tick_cnt_n = tick_cnt + 16'd1;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_mod.sv
// Directed bench for mod: one instance at DIV=42 and one at DIV=1, sharing a clock.
module tb_mod;

  logic        clk = 1'b0;
  logic        rst_a, start_a, stop_a;
  logic        tick_a, wave_a, busy_a;
  logic [7:0]  cnt_a;
  logic [15:0] tcnt_a;
  logic        rst_b, start_b, stop_b;
  logic        tick_b, wave_b, busy_b;
  logic [7:0]  cnt_b;
  logic [15:0] tcnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mod #(.DIV(42)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .stop(stop_a),
    .tick(tick_a), .wave(wave_a), .busy(busy_a), .cnt_q(cnt_a), .tick_cnt(tcnt_a)
  );

  mod #(.DIV(1)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .stop(stop_b),
    .tick(tick_b), .wave(wave_b), .busy(busy_b), .cnt_q(cnt_b), .tick_cnt(tcnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int seen;
    int b_steps;
    rst_a = 1'b1; start_a = 1'b0; stop_a = 1'b0;
    rst_b = 1'b1; start_b = 1'b0; stop_b = 1'b0;
    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_tick", tick_a, 0);
    chk("rst_wave", wave_a, 0);
    chk("rst_tcnt", tcnt_a, 0);
    step(2);
    rst_a = 1'b0;
    step(2);
    chk("idle_busy", busy_a, 0);

    // first tick latency
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    chk("run_busy", busy_a, 1);
    chk("run_cnt0", cnt_a, 0);
    step(41);
    chk("pre_tick_cnt", cnt_a, 41);
    chk("pre_tick", tick_a, 0);
    step(1);
    chk("tick1", tick_a, 1);
    chk("tick1_wave", wave_a, 1);
    chk("tick1_tcnt", tcnt_a, 1);
    chk("tick1_cnt", cnt_a, 0);
    step(1);
    chk("tick1_end", tick_a, 0);
    chk("tick1_end_cnt", cnt_a, 1);

    // start while running is ignored
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    chk("start_in_run_cnt", cnt_a, 2);
    step(39);
    chk("pre_tick2", tick_a, 0);
    step(1);
    chk("tick2", tick_a, 1);
    chk("tick2_wave", wave_a, 0);
    chk("tick2_tcnt", tcnt_a, 2);

    // stop mid-period
    step(20);
    chk("mid_cnt", cnt_a, 20);
    stop_a = 1'b1;
    step(1);
    stop_a = 1'b0;
    chk("stop_busy", busy_a, 0);
    chk("stop_cnt", cnt_a, 0);
    chk("stop_tick", tick_a, 0);
    chk("stop_wave", wave_a, 0);
    chk("stop_tcnt", tcnt_a, 2);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (tick_a) seen++;
    end
    chk("idle_ticks", seen, 0);
    chk("idle_tcnt", tcnt_a, 2);

    // start and stop together in IDLE
    start_a = 1'b1; stop_a = 1'b1;
    step(1);
    start_a = 1'b0; stop_a = 1'b0;
    chk("both_busy", busy_a, 0);
    chk("both_cnt", cnt_a, 0);

    // stop on the terminal phase suppresses the tick
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    step(41);
    chk("last_cnt", cnt_a, 41);
    stop_a = 1'b1;
    step(1);
    stop_a = 1'b0;
    chk("stop_last_tick", tick_a, 0);
    chk("stop_last_wave", wave_a, 0);
    chk("stop_last_tcnt", tcnt_a, 2);
    chk("stop_last_busy", busy_a, 0);

    // async reset between edges at the terminal phase
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    step(41);
    chk("arst_pre_cnt", cnt_a, 41);
    #2 rst_a = 1'b1;
    #1;
    chk("arst_busy", busy_a, 0);
    chk("arst_cnt", cnt_a, 0);
    chk("arst_tick", tick_a, 0);
    chk("arst_wave", wave_a, 0);
    chk("arst_tcnt", tcnt_a, 0);
    step(2);
    rst_a = 1'b0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (tick_a || busy_a) seen++;
    end
    chk("arst_quiet", seen, 0);
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    chk("arst_restart_busy", busy_a, 1);
    chk("arst_restart_cnt", cnt_a, 0);

    // DIV=1: tick every cycle, then saturation
    rst_b = 1'b0;
    step(1);
    start_b = 1'b1;
    step(1);
    start_b = 1'b0;
    chk("d1_busy", busy_b, 1);
    chk("d1_tick0", tick_b, 0);
    b_steps = 0;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      b_steps++;
      chk("d1_tick", tick_b, 1);
      chk("d1_wave", wave_b, i % 2);
      chk("d1_tcnt", tcnt_b, i);
      chk("d1_cnt", cnt_b, 0);
    end
    step(70000);
    b_steps += 70000;
    chk("d1_sat_tcnt", tcnt_b, 32'h0000FFFF);
    chk("d1_sat_tick", tick_b, 1);
    chk("d1_sat_wave", wave_b, b_steps % 2);
    step(1);
    b_steps++;
    chk("d1_sat_tcnt2", tcnt_b, 32'h0000FFFF);
    chk("d1_sat_wave2", wave_b, b_steps % 2);
    chk("d1_sat_tick2", tick_b, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
